// File: rtl/spi_phy_pkg.sv
// Shared types and widths for the SPI master PHY.
//   state_e   : transfer FSM states (3-bit encoding)
//   WORD_W    : transfer word width
//   BYTE_W    : byte width (back-pressure granularity)
//   BIT_CNT_W : width of the per-word bit counter
package spi_phy_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Index of the final bit for a transfer of (len+1) bytes.
  function automatic logic [BIT_CNT_W-1:0] last_bit(input logic [1:0] len);
    return BIT_CNT_W'((32'(len) + 32'd1) * BYTE_W - 32'd1);
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK half-period timer. Counts CLK_DIV clk cycles per SCK phase and emits a
// one-cycle strobe at the end of each phase: rise_c ends a low phase, fall_c
// ends a high phase.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : count (transfer is in an SCK low/high phase)
//   clr        : hold the counter at zero (idle or byte-boundary gap)
//   phase_hi   : current phase is SCK high
//   rise_c     : combinational strobe, SCK should rise next cycle
//   fall_c     : combinational strobe, SCK should fall next cycle
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic phase_hi,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;

  assign tick_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_c = tick_c && !phase_hi;
  assign fall_c = tick_c && phase_hi;

  // Phase counter; wraps at each strobe so the next phase starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick_c) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_phy.sv
// SPI master PHY (mode 0) for the LCD interface. Shifts a 32-bit word out
// MSB-first on sck_o/mosi_o while capturing miso_i, drives chip select and
// stalls SCK at byte boundaries when the host drops spi_ready.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   spi_mosi / spi_miso : word to send (latched on begin) / last word received
//   spi_begin           : start strobe, accepted only while idle
//   spi_ready           : host ready, sampled at byte boundaries
//   spi_busy            : transfer in progress
//   spi_cs              : host chip-select request
//   sck_o, mosi_o, miso_i, cs_n_o : SPI pins
// Optional feature macro SPI_PHY_BYTE_LEN_EN adds spi_len[1:0] selecting a
// 1..4 byte transfer from the top of spi_mosi; received bytes land right-aligned.
module spi_phy
  import spi_phy_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] spi_mosi,
  output logic [WORD_W-1:0] spi_miso,
  input  logic              spi_begin,
  input  logic              spi_ready,
  output logic              spi_busy,
  input  logic              spi_cs,
  output logic              sck_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic              cs_n_o
`ifdef SPI_PHY_BYTE_LEN_EN
  ,
  input  logic [1:0]        spi_len
`endif
);

  state_e                 state_q, state_d;
  logic [WORD_W-1:0]      tx_q, rx_q;
  logic [BIT_CNT_W-1:0]   bit_cnt_q;
  logic [BIT_CNT_W-1:0]   last_bit_c;
  logic                   rise_c, fall_c;

`ifdef SPI_PHY_BYTE_LEN_EN
  logic [BIT_CNT_W-1:0]   last_bit_q;

  // Transfer length captured with the begin strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bit_q <= last_bit(2'd3);
    end else if (state_q == IDLE && spi_begin) begin
      last_bit_q <= last_bit(spi_len);
    end
  end

  assign last_bit_c = last_bit_q;
`else
  assign last_bit_c = last_bit(2'd3);
`endif

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == LOW || state_q == HIGH),
    .clr      (state_q == IDLE || state_q == GAP),
    .phase_hi (state_q == HIGH),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; byte-boundary stall checked only after bits 8/16/24.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (spi_begin) state_d = SETUP;
      SETUP: state_d = LOW;
      LOW:   if (rise_c) state_d = HIGH;
      HIGH: begin
        if (fall_c) begin
          if (bit_cnt_q == last_bit_c) begin
            state_d = DONE;
          end else if (bit_cnt_q[2:0] == 3'b111 && !spi_ready) begin
            state_d = GAP;
          end else begin
            state_d = LOW;
          end
        end
      end
      GAP:   if (spi_ready) state_d = LOW;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered pin/host outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      spi_miso  <= '0;
      spi_busy  <= 1'b0;
      sck_o     <= 1'b0;
      mosi_o    <= 1'b0;
      cs_n_o    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          cs_n_o <= ~spi_cs;
          if (spi_begin) begin
            tx_q      <= spi_mosi;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            mosi_o    <= spi_mosi[WORD_W-1];
            cs_n_o    <= 1'b0;
            spi_busy  <= 1'b1;
          end
        end
        LOW: begin
          if (rise_c) begin
            sck_o <= 1'b1;
            rx_q  <= {rx_q[WORD_W-2:0], miso_i};
          end
        end
        HIGH: begin
          if (fall_c) begin
            sck_o     <= 1'b0;
            tx_q      <= {tx_q[WORD_W-2:0], 1'b0};
            mosi_o    <= tx_q[WORD_W-2];
            bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
          end
        end
        DONE: begin
          spi_miso <= rx_q;
          spi_busy <= 1'b0;
          // Chip select follows the host again from the first idle cycle.
          cs_n_o   <= ~spi_cs;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_phy.sv
// Scoreboard bench for spi_phy (CLK_DIV=2). Each issued transfer pushes its
// expected received word, busy length, SCK rise count, count of mosi_o ones at
// SCK rises; a monitor pops and compares when spi_busy falls.
module tb_spi_phy;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] spi_mosi;
  logic [31:0] spi_miso;
  logic        spi_begin;
  logic        spi_ready;
  logic        spi_busy;
  logic        spi_cs;
  logic        sck_o;
  logic        mosi_o;
  logic        miso_i;
  logic        cs_n_o;
`ifdef SPI_PHY_BYTE_LEN_EN
  logic [1:0]  spi_len;
`endif

  logic        loop_en;
  logic        miso_const;
  logic        watch_cs;
  int          cs_gap_hi;
  int          tests;
  int          fails;

  typedef struct {
    logic [31:0] data;
    int          busy;
    int          rises;
    int          ones;
  } exp_t;

  exp_t q[$];

  assign miso_i = loop_en ? mosi_o : miso_const;

  always #5 clk = ~clk;

  spi_phy #(.CLK_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_begin (spi_begin),
    .spi_ready (spi_ready),
    .spi_busy  (spi_busy),
    .spi_cs    (spi_cs),
    .sck_o     (sck_o),
    .mosi_o    (mosi_o),
    .miso_i    (miso_i),
    .cs_n_o    (cs_n_o)
`ifdef SPI_PHY_BYTE_LEN_EN
    ,
    .spi_len   (spi_len)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one transfer starting at the current negedge.
  task automatic xfer(input logic [31:0] d, input logic [1:0] len);
    spi_mosi  = d;
`ifdef SPI_PHY_BYTE_LEN_EN
    spi_len   = len;
`else
    if (len != 2'd3) $display("[TB] short length ignored in 4-byte build");
`endif
    spi_begin = 1'b1;
    @(negedge clk);
    spi_begin = 1'b0;
  endtask

  // Wait (bounded) for the first cycle with spi_busy low.
  task automatic wait_idle();
    int n = 0;
    while (spi_busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", 32'(spi_busy), 32'd0);
  endtask

  // Monitor state
  logic mon_pb, mon_ps;
  int   mon_bc, mon_rc, mon_oc, mon_ch;
  exp_t mon_e;

  initial begin
    mon_pb = 1'b0; mon_ps = 1'b0;
    mon_bc = 0; mon_rc = 0; mon_oc = 0; mon_ch = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pb = 1'b0; mon_ps = 1'b0;
        mon_bc = 0; mon_rc = 0; mon_oc = 0; mon_ch = 0;
      end else begin
        if (spi_busy) begin
          mon_bc++;
          if (sck_o && !mon_ps) begin
            mon_rc++;
            if (mosi_o) mon_oc++;
          end
          if (cs_n_o) mon_ch++;
        end
        if (watch_cs && cs_n_o) cs_gap_hi++;
        if (mon_pb && !spi_busy) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got completion, expected none (miso %h)", spi_miso);
          end else begin
            mon_e = q.pop_front();
            check("miso",           spi_miso,       mon_e.data);
            check("busy_cycles",    32'(mon_bc),    32'(mon_e.busy));
            check("sck_rises",      32'(mon_rc),    32'(mon_e.rises));
            check("mosi_ones",      32'(mon_oc),    32'(mon_e.ones));
            check("cs_during_busy", 32'(mon_ch),    32'd0);
          end
          mon_bc = 0; mon_rc = 0; mon_oc = 0; mon_ch = 0;
        end
        mon_pb = spi_busy;
        mon_ps = sck_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests = 0; fails = 0; cs_gap_hi = 0; watch_cs = 1'b0;
    rst_n = 1'b0; spi_begin = 1'b0; spi_mosi = '0; spi_ready = 1'b1;
    spi_cs = 1'b0; loop_en = 1'b1; miso_const = 1'b0;
`ifdef SPI_PHY_BYTE_LEN_EN
    spi_len = 2'd3;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sck",  32'(sck_o),    32'd0);
    check("rst_mosi", 32'(mosi_o),   32'd0);
    check("rst_cs_n", 32'(cs_n_o),   32'd1);
    check("rst_busy", 32'(spi_busy), 32'd0);
    check("rst_miso", spi_miso,      32'd0);
    rst_n = 1'b1;

    // Idle chip select follows spi_cs with one cycle of latency
    @(negedge clk);
    check("idle_cs_off", 32'(cs_n_o), 32'd1);
    spi_cs = 1'b1;
    @(negedge clk);
    check("idle_cs_on", 32'(cs_n_o), 32'd0);
    spi_cs = 1'b0;
    @(negedge clk);
    check("idle_cs_release", 32'(cs_n_o), 32'd1);

    // Loopback word
    q.push_back('{32'hA5C3_0F81, 130, 32, 14});
    xfer(32'hA5C3_0F81, 2'd3);
    wait_idle();
    @(negedge clk);

    // MISO tied high, all-zero transmit
    loop_en = 1'b0; miso_const = 1'b1;
    q.push_back('{32'hFFFF_FFFF, 130, 32, 0});
    xfer(32'h0000_0000, 2'd3);
    wait_idle();
    loop_en = 1'b1;
    @(negedge clk);

    // Host stalls 10 cycles after the first byte
    q.push_back('{32'h1234_5678, 140, 32, 13});
    xfer(32'h1234_5678, 2'd3);
    repeat (20) @(negedge clk);
    spi_ready = 1'b0;
    repeat (22) @(negedge clk);
    spi_ready = 1'b1;
    wait_idle();
    @(negedge clk);

    // Back-to-back words with chip select held
    spi_cs = 1'b1;
    repeat (2) @(negedge clk);
    watch_cs = 1'b1;
    q.push_back('{32'hDEAD_BEEF, 130, 32, 24});
    xfer(32'hDEAD_BEEF, 2'd3);
    wait_idle();
    q.push_back('{32'h0000_FFFF, 130, 32, 16});
    xfer(32'h0000_FFFF, 2'd3);
    wait_idle();
    @(negedge clk);
    watch_cs = 1'b0;
    check("cs_held_between_words", 32'(cs_gap_hi), 32'd0);
    spi_cs = 1'b0;
    @(negedge clk);

    // Reset during bit 17 aborts the transfer
    xfer(32'hCAFE_F00D, 2'd3);
    repeat (70) @(negedge clk);
    check("pre_abort_busy", 32'(spi_busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_sck",  32'(sck_o),    32'd0);
    check("abort_cs_n", 32'(cs_n_o),   32'd1);
    check("abort_busy", 32'(spi_busy), 32'd0);
    check("abort_miso", spi_miso,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal transfer after the abort
    q.push_back('{32'h0F0F_55AA, 130, 32, 16});
    xfer(32'h0F0F_55AA, 2'd3);
    wait_idle();
    @(negedge clk);

`ifdef SPI_PHY_BYTE_LEN_EN
    // Single-byte transfer
    q.push_back('{32'h0000_003C, 34, 8, 4});
    xfer(32'h3C00_0000, 2'd0);
    wait_idle();
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
